// File: rtl/result_writer.sv
// Avalon-MM write master: stores one NDWORDS x 32-bit record to SDRAM as 16-bit halfwords.
// Optional macro RESULT_WRITER_CNT_EN adds o_rec_cnt, the count of records fully written.
module result_writer #(
   parameter int unsigned NDWORDS = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [31:0]             i_baseaddr,
   input  logic [31:0]             i_index,
   input  logic [32*NDWORDS-1:0]   i_data,
   input  logic                    i_valid,
   output logic                    o_ready,
   output logic                    o_done,
   output logic                    o_busy,
`ifdef RESULT_WRITER_CNT_EN
   output logic [31:0]             o_rec_cnt,
`endif
   output logic                    avm_m0_write,
   output logic [31:0]             avm_m0_address,
   output logic [15:0]             avm_m0_writedata,
   output logic [1:0]              avm_m0_byteenable,
   input  logic                    avm_m0_waitrequest
);

   localparam int unsigned NumHw  = 2 * NDWORDS;
   localparam int unsigned HwW    = (NumHw > 1) ? $clog2(NumHw) : 1;
   localparam logic [HwW-1:0] LastHw = HwW'(NumHw - 1);
   localparam logic [31:0] Stride = 32'(NDWORDS * 4);

   typedef enum logic [0:0] {StIdle, StWrite} state_e;

   state_e                  r_state;
   state_e                  w_state_next;
   logic [HwW-1:0]          r_hw;
   logic [32*NDWORDS-1:0]   r_data;
   logic                    w_accept;
   logic                    w_hw_acc;
   logic                    w_last;
   logic [31:0]             w_rec_addr;

   assign o_ready    = i_rstn && (r_state == StIdle);
   assign w_accept   = i_valid && o_ready;
   assign w_hw_acc   = avm_m0_write && !avm_m0_waitrequest;
   assign w_last     = (r_hw == LastHw);
   // 32-bit product: overflow wraps silently
   assign w_rec_addr = i_baseaddr + i_index * Stride;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StWrite;
         StWrite: if (w_hw_acc && w_last) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state           <= StIdle;
         r_hw              <= '0;
         r_data            <= '0;
         o_done            <= 1'b0;
         o_busy            <= 1'b0;
         avm_m0_write      <= 1'b0;
         avm_m0_address    <= '0;
         avm_m0_writedata  <= '0;
         avm_m0_byteenable <= '0;
`ifdef RESULT_WRITER_CNT_EN
         o_rec_cnt         <= '0;
`endif
      end else begin
         r_state <= w_state_next;
         o_busy  <= (w_state_next == StWrite);
         o_done  <= 1'b0;
         if (w_accept) begin
            r_data            <= i_data;
            r_hw              <= '0;
            avm_m0_write      <= 1'b1;
            avm_m0_address    <= w_rec_addr;
            avm_m0_writedata  <= i_data[15:0];
            avm_m0_byteenable <= 2'b11;
         end else if (w_hw_acc) begin
            if (w_last) begin
               avm_m0_write      <= 1'b0;
               avm_m0_byteenable <= 2'b00;
               o_done            <= 1'b1;
`ifdef RESULT_WRITER_CNT_EN
               o_rec_cnt         <= o_rec_cnt + 32'd1;
`endif
            end else begin
               // r_data shifts down so the next halfword always sits at [31:16]
               r_hw             <= r_hw + 1'b1;
               avm_m0_address   <= avm_m0_address + 32'd2;
               avm_m0_writedata <= r_data[31:16];
               r_data           <= r_data >> 16;
            end
         end
      end
   end

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer; checks o_rec_cnt too when RESULT_WRITER_CNT_EN is defined.
module tb_result_writer;

   localparam int unsigned N = 3;

   logic             clk = 1'b0;
   logic             i_rstn = 1'b0;
   logic [31:0]      i_baseaddr = '0;
   logic [31:0]      i_index = '0;
   logic [32*N-1:0]  i_data = '0;
   logic             i_valid = 1'b0;
   logic             o_ready, o_done, o_busy;
   logic             avm_m0_write;
   logic [31:0]      avm_m0_address;
   logic [15:0]      avm_m0_writedata;
   logic [1:0]       avm_m0_byteenable;
   logic             avm_m0_waitrequest = 1'b0;
`ifdef RESULT_WRITER_CNT_EN
   logic [31:0]      o_rec_cnt;
`endif

   always #5 clk = ~clk;

   result_writer #(.NDWORDS(N)) dut (
      .i_clk              (clk),
      .i_rstn             (i_rstn),
      .i_baseaddr         (i_baseaddr),
      .i_index            (i_index),
      .i_data             (i_data),
      .i_valid            (i_valid),
      .o_ready            (o_ready),
      .o_done             (o_done),
      .o_busy             (o_busy),
`ifdef RESULT_WRITER_CNT_EN
      .o_rec_cnt          (o_rec_cnt),
`endif
      .avm_m0_write       (avm_m0_write),
      .avm_m0_address     (avm_m0_address),
      .avm_m0_writedata   (avm_m0_writedata),
      .avm_m0_byteenable  (avm_m0_byteenable),
      .avm_m0_waitrequest (avm_m0_waitrequest)
   );

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
      int          hw;
      bit          last;
   } hw_t;

   hw_t         exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          hw_acc = 0;
   logic [31:0] exp_cnt = '0;
   bit          rand_wait = 1'b0;
   int          stall_hw = -1;
   int          stall_len = 0;
   int          stall_cnt = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: record k-th halfword lives at base + idx*stride + 2k, low half of each word first
   function automatic void push_record(input logic [31:0] base, input logic [31:0] idx,
                                       input logic [32*N-1:0] d);
      logic [31:0] a;
      a = base + idx * (N * 4);
      for (int k = 0; k < 2 * int'(N); k++) begin
         hw_t e;
         e.addr = a + 32'(2 * k);
         e.data = d[16*k +: 16];
         e.hw   = k;
         e.last = (k == 2 * int'(N) - 1);
         exp_q.push_back(e);
      end
   endfunction

   // Slave model: random stalls, or a directed stall on one halfword index
   always @(posedge clk) begin
      #1;
      if (rand_wait) begin
         avm_m0_waitrequest = ($urandom_range(0, 2) == 0);
      end else if (avm_m0_write && exp_q.size() > 0 && exp_q[0].hw == stall_hw &&
                   stall_cnt < stall_len) begin
         avm_m0_waitrequest = 1'b1;
         stall_cnt++;
      end else begin
         avm_m0_waitrequest = 1'b0;
      end
   end

   // Monitor
   bit          prev_last = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_addr;
   logic [15:0] prev_data;

   always @(negedge clk) begin
      if (!i_rstn) begin
         prev_last  = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (o_done || prev_last) check("done_after_last_hw", 32'(o_done), 32'(prev_last));
`ifdef RESULT_WRITER_CNT_EN
         if (o_done) check("rec_cnt", o_rec_cnt, exp_cnt);
`endif
         prev_last = 1'b0;
         if (prev_stall) begin
            check("stall_hold_write", 32'(avm_m0_write), 32'd1);
            check("stall_hold_addr", avm_m0_address, prev_addr);
            check("stall_hold_data", 32'(avm_m0_writedata), 32'(prev_data));
         end
         prev_stall = avm_m0_write && avm_m0_waitrequest;
         prev_addr  = avm_m0_address;
         prev_data  = avm_m0_writedata;
         if (avm_m0_write && !avm_m0_waitrequest) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", avm_m0_address, 32'hxxxx_xxxx);
            end else begin
               hw_t e;
               e = exp_q.pop_front();
               check("hw_addr", avm_m0_address, e.addr);
               check("hw_data", 32'(avm_m0_writedata), 32'(e.data));
               check("hw_byteenable", 32'(avm_m0_byteenable), 32'd3);
               prev_last = e.last;
               hw_acc++;
               if (e.last) exp_cnt = exp_cnt + 32'd1;
            end
         end
      end
   end

   // Call just after a rising edge; returns just after the accepting edge
   task automatic accept(input logic [31:0] base, input logic [31:0] idx,
                         input logic [32*N-1:0] d, input bit hold,
                         output int waited, output bit done_seen);
      i_baseaddr = base;
      i_index    = idx;
      i_data     = d;
      i_valid    = 1'b1;
      waited     = 0;
      @(negedge clk);
      while (!o_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!o_ready) check("accept_timeout", 32'(o_ready), 32'd1);
      done_seen = o_done;
      push_record(base, idx, d);
      @(posedge clk);
      #1;
      if (!hold) i_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!o_done && lat < 200);
      if (!o_done) check("done_timeout", 32'(o_done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int                w;
      int                lat;
      bit                d;
      int                start;
      int                guard;
      logic [32*N-1:0]   rec;

      rec = {32'h0000_0005, 32'h0001_0002, 32'h0000_0001};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_write", 32'(avm_m0_write), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_addr", avm_m0_address, 32'd0);
      check("rst_wdata", 32'(avm_m0_writedata), 32'd0);
      check("rst_be", 32'(avm_m0_byteenable), 32'd0);
      check("rst_ready_low", 32'(o_ready), 32'd0);
`ifdef RESULT_WRITER_CNT_EN
      check("rst_cnt", o_rec_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      i_rstn = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(o_ready), 32'd1);
      @(posedge clk);
      #1;

      // Basic record
      accept(32'h0000_1000, 32'd2, rec, 1'b0, w, d);
      @(negedge clk);
      check("basic_busy", 32'(o_busy), 32'd1);
      check("basic_ready_low", 32'(o_ready), 32'd0);
      @(posedge clk);
      #1;
      wait_done(lat);
      check("basic_latency", 32'(lat), 32'd6);

      // Stall on halfword 2 for 3 cycles
      stall_hw  = 2;
      stall_len = 3;
      stall_cnt = 0;
      accept(32'h0000_1000, 32'd2, rec, 1'b0, w, d);
      wait_done(lat);
      check("stall_latency", 32'(lat), 32'd10);
      stall_hw = -1;

      // Back-to-back with i_valid held
      accept(32'h0000_1000, 32'd2, rec, 1'b1, w, d);
      accept(32'h0000_1000, 32'd3, {32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF}, 1'b0, w, d);
      check("b2b_wait_cycles", 32'(w), 32'd6);
      check("b2b_accept_in_done", 32'(d), 32'd1);
      @(negedge clk);
      check("b2b_first_write", 32'(avm_m0_write), 32'd1);
      check("b2b_first_addr", avm_m0_address, 32'h0000_1024);
      @(posedge clk);
      #1;
      wait_done(lat);
      check("b2b_latency", 32'(lat), 32'd6);

      // Address wrap
      accept(32'hFFFF_FFF8, 32'd1, {$urandom, $urandom, $urandom}, 1'b0, w, d);
      wait_done(lat);
      check("wrap_latency", 32'(lat), 32'd7);

      // Stall on last halfword; queued request must wait for o_done
      stall_hw  = 5;
      stall_len = 2;
      stall_cnt = 0;
      accept(32'h0000_2000, 32'd0, rec, 1'b1, w, d);
      accept(32'h0000_2000, 32'd1, {$urandom, $urandom, $urandom}, 1'b0, w, d);
      check("last_stall_wait", 32'(w), 32'd8);
      check("last_stall_accept_in_done", 32'(d), 32'd1);
      stall_hw = -1;
      wait_done(lat);
      check("last_stall_next_latency", 32'(lat), 32'd7);

      // Reset after third halfword accepted
      start = hw_acc;
      accept(32'h0000_3000, 32'd0, {$urandom, $urandom, $urandom}, 1'b0, w, d);
      guard = 0;
      while (hw_acc < start + 3 && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("mid_rst_reached_hw3", 32'(hw_acc - start), 32'd3);
      i_rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_write_low", 32'(avm_m0_write), 32'd0);
      check("mid_rst_no_done", 32'(o_done), 32'd0);
      check("mid_rst_busy_low", 32'(o_busy), 32'd0);
      exp_q.delete();
      exp_cnt = '0;
`ifdef RESULT_WRITER_CNT_EN
      check("mid_rst_cnt", o_rec_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      i_rstn = 1'b1;
      @(negedge clk);
      check("mid_rst_ready", 32'(o_ready), 32'd1);
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_no_late_done", 32'(o_done), 32'd0);
      end
      @(posedge clk);
      #1;

      // Random traffic with random slave stalls
      rand_wait = 1'b1;
      for (int r = 0; r < 25; r++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         accept($urandom, $urandom, {$urandom, $urandom, $urandom}, 1'b0, w, d);
         wait_done(lat);
         check("rand_latency_min", 32'(lat >= 7), 32'd1);
      end
      rand_wait = 1'b0;
      repeat (3) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
